// File: rtl/wb_port_arbiter_if.sv
// Write-back bus between the execute units and the register-file write port.
// slave = arbiter side, master = requesters / register file side.
interface wb_port_arbiter_if #(
    parameter int Size     = 64,
    parameter int AddrSize = 5
);
    logic [2:0]            valid_i;
    logic [3*AddrSize-1:0] addr_i;
    logic [3*Size-1:0]     data_i;
    logic                  hold_i;
    logic [2:0]            ready_o;
    logic                  load_o;
    logic [AddrSize-1:0]   addr_o;
    logic [Size-1:0]       data_o;
    logic                  busy_o;

    modport slave (
        input  valid_i, addr_i, data_i, hold_i,
        output ready_o, load_o, addr_o, data_o, busy_o
    );

    modport master (
        output valid_i, addr_i, data_i, hold_i,
        input  ready_o, load_o, addr_o, data_o, busy_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing one register-file write port between ALU (0),
// MUL/DIV (1) and FPU (2); the winning write is registered onto the port.
module wb_port_arbiter #(
    parameter int Size     = 64,
    parameter int AddrSize = 5,
    parameter bit DropZero = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    wb_port_arbiter_if.slave   wb
);
    localparam int NUM_LANES = 3;

    logic [NUM_LANES-1:0][AddrSize-1:0] addr_lane;
    logic [NUM_LANES-1:0][Size-1:0]     data_lane;
    logic [1:0]                         ptr;
    logic [NUM_LANES-1:0]               grant;
    logic [1:0]                         sel;
    logic                               xfer;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign addr_lane[k] = wb.addr_i[k*AddrSize +: AddrSize];
        assign data_lane[k] = wb.data_i[k*Size +: Size];
    end

    // Scan ptr, ptr+1, ptr+2 (mod 3); first valid requester wins.
    always_comb begin
        logic       found;
        logic [2:0] sum;
        logic [1:0] idx;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        if (!reset && !wb.hold_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                sum = {1'b0, ptr} + 3'(i);
                idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                if (!found && wb.valid_i[idx]) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (grant[i]) sel = 2'(i);
    end

    // grant only ever lands on a valid lane, so any grant is a transfer
    assign xfer       = |grant;
    assign wb.ready_o = grant;
    assign wb.busy_o  = !reset && (|wb.valid_i) && !xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            wb.load_o <= 1'b0;
            wb.addr_o <= '0;
            wb.data_o <= '0;
        end else if (xfer) begin
            ptr       <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            wb.addr_o <= addr_lane[sel];
            wb.data_o <= data_lane[sel];
            wb.load_o <= !(DropZero && (addr_lane[sel] == '0));
        end else begin
            wb.load_o <= 1'b0;
        end
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between three write-back requesters: 0 = integer ALU, 1 = multiply/divide unit, 2 = FPU.
- Selects one requester per cycle using round-robin priority.
- Drives the write port (load, address, data) from an output register, so each write lands exactly one cycle after its grant.
- Sits between the execute units and the register file in the RV64F datapath.

Parameters:
- Size, 64: data width of each requester and of the write port.
- AddrSize, 5: register address width.
- DropZero, 1: when 1, a granted write to address 0 is accepted but does not assert load_o (integer file use); when 0, address 0 is written normally (FP file use).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  3  per-requester write request; bit k belongs to requester k.
- addr_i  input  3*AddrSize  destination addresses; slice k = addr_i[k*AddrSize +: AddrSize].
- data_i  input  3*Size  write data; slice k = data_i[k*Size +: Size].
- hold_i  input  1  when 1, no grant is issued this cycle.
- ready_o  output  3  one-hot grant; a transfer occurs for requester k when valid_i[k] & ready_o[k].
- load_o  output  1  write enable to the register file.
- addr_o  output  AddrSize  write address to the register file.
- data_o  output  Size  write data to the register file.
- busy_o  output  1  1 when any valid_i bit is set and none is granted this cycle (stall visibility).

Behaviour:
- Reset (synchronous, on a clk edge with reset=1):
  - load_o=0, addr_o=0, data_o=0.
  - Round-robin pointer ptr=0.
  - reset overrides all requests in that cycle.
- ready_o and busy_o are combinational. While reset=1: ready_o=0 and busy_o=0.
- Grant selection (combinational, each cycle):
  - If hold_i=1 or valid_i=0: ready_o=0.
  - Otherwise grant the first valid requester found scanning ptr, ptr+1, ptr+2 (mod 3).
  - At most one ready_o bit is ever set.
  - ready_o[k] is never set while valid_i[k]=0.
- Pointer update (registered):
  - On a transfer by requester k: ptr <= (k+1) mod 3.
  - With no transfer, ptr holds.
  - The pointer values wrap 2 -> 0.
- Output register:
  - On a transfer by k: addr_o <= addr slice k; data_o <= data slice k; load_o <= 1. Exception: when DropZero=1 and addr slice k = 0, load_o <= 0 (addr_o and data_o still update).
  - With no transfer: load_o <= 0; addr_o and data_o hold their previous values.
- Latency: a write is presented on the port in the cycle after its handshake. Back-to-back transfers give a continuous load_o=1.
- Requester contract: once valid_i[k]=1, the requester holds valid, addr and data stable until it sees ready_o[k]. The arbiter does not capture data before the grant.
- Fairness: with all three valid continuously, grants cycle 0,1,2,0,... Each requester waits at most 2 cycles while hold_i=0.
- Reset asserted while requests are pending:
  - Pending requests are not granted in the reset cycle.
  - Arbitration restarts from ptr=0 on the first cycle after reset deasserts.
  - A write already registered is cancelled (load_o=0 in the next cycle).
- hold_i=1: ptr and the output registers behave as in a no-transfer cycle; busy_o=1 if any valid_i bit is set.

Test Plan:
- Reset check: drive reset=1 with valid_i=3'b111 for 2 cycles -> ready_o=0 throughout; after that, load_o=0, addr_o=0, data_o=0; first grant after release goes to requester 0.
- Single requester: valid_i=3'b010, addr slice 1 = 5'd7, data slice 1 = 64'hDEADBEEF_00000001 -> ready_o=3'b010 in the same cycle; next cycle load_o=1, addr_o=7, data_o=64'hDEADBEEF_00000001; ptr=2.
- Round-robin: hold valid_i=3'b111 for 6 cycles with distinct addresses 1/2/3 -> grant sequence 0,1,2,0,1,2; addr_o sequence 1,2,3,1,2,3 lagging one cycle; load_o continuously 1.
- Pointer wrap / skip: ptr=2 and valid_i=3'b011 -> requester 0 granted, then requester 1; requester 2 never granted.
- hold_i and DropZero: hold_i=1 with valid_i=3'b001 -> ready_o=0, busy_o=1, load_o=0. Then release hold_i with addr slice 0 = 0: DropZero=1 gives ready_o=3'b001 and next-cycle load_o=0; DropZero=0 gives next-cycle load_o=1.
- Randomized: 1000 cycles of random valid_i/hold_i, with requesters obeying the hold contract -> each written addr/data matches a scoreboard model; ready_o is one-hot or zero; no requester waits more than 2 non-hold cycles.
